// File: rtl/dj_pkg.sv
// Shared constants and FSM state type for the Dijkstra solver and its path tracer.
package dj_pkg;

  localparam int N_NODES = 13;
  localparam int NODE_W  = 4;
  localparam int DIST_W  = 14;
  localparam logic [DIST_W-1:0] INF_DIST = 14'd99;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TRACE = 3'd1,
    EMIT  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/dj_lifo.sv
// Node-id LIFO used by the path tracer to reverse the predecessor walk.
module dj_lifo
  import dj_pkg::*;
(
  input  logic              clk,
  input  logic              push,
  input  logic              pop,
  input  logic              clr,
  input  logic [NODE_W-1:0] din,
  output logic [NODE_W-1:0] dout,
  output logic [NODE_W:0]   count
);

  logic [NODE_W-1:0] mem [N_NODES];
  logic [NODE_W:0]   sp;
  logic [NODE_W:0]   top_ptr;

  assign count   = sp;
  assign top_ptr = sp - 1'b1;
  assign dout    = (sp == '0) ? '0 : mem[top_ptr[NODE_W-1:0]];

  always_ff @(posedge clk) begin
    if (clr) begin
      sp <= '0;
    end else if (push) begin
      sp <= sp + 1'b1;
    end else if (pop && (sp != '0)) begin
      sp <= sp - 1'b1;
    end
  end

  // Storage carries no reset; only the stack pointer decides what is live.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[sp[NODE_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/dj_path_tracer.sv
// Walks the solver's predecessor table end->start, then streams the path start->end.
// Optional DJ_PATH_LEN_EN adds a path_len output holding the node count of the last path.
module dj_path_tracer
  import dj_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NODE_W-1:0] start_node,
  input  logic [NODE_W-1:0] end_node,
  input  logic [DIST_W-1:0] end_dist,
  output logic [NODE_W-1:0] pred_addr,
  input  logic [NODE_W-1:0] pred_data,
  output logic [NODE_W-1:0] out_node,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              error
`ifdef DJ_PATH_LEN_EN
  ,
  output logic [NODE_W:0]   path_len
`endif
);

  localparam logic [NODE_W:0] LEN_MAX = (NODE_W+1)'(N_NODES);

  state_t            state;
  logic [NODE_W-1:0] s_node;
  logic [NODE_W-1:0] cur;
  logic [NODE_W:0]   len;
  logic [NODE_W:0]   len_next;
  logic              trace_hit;
  logic              trace_full;

  logic              lifo_push;
  logic              lifo_pop;
  logic              lifo_clr;
  logic [NODE_W-1:0] lifo_top;
  logic [NODE_W:0]   lifo_count;
  logic              last_beat;

  assign len_next   = len + 1'b1;
  assign trace_hit  = (cur == s_node);
  assign trace_full = (len_next == LEN_MAX);

  assign lifo_push  = (state == TRACE);
  assign lifo_pop   = (state == EMIT) && out_ready;
  assign lifo_clr   = rst || (state == ERR);
  assign last_beat  = (lifo_count == (NODE_W+1)'(1));

  dj_lifo u_lifo (
    .clk   (clk),
    .push  (lifo_push),
    .pop   (lifo_pop),
    .clr   (lifo_clr),
    .din   (cur),
    .dout  (lifo_top),
    .count (lifo_count)
  );

  // Reaching the source on the final permitted step is a valid path, so the hit test wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      s_node <= '0;
      cur    <= '0;
      len    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (end_dist == INF_DIST) begin
              state <= ERR;
            end else begin
              s_node <= start_node;
              cur    <= end_node;
              len    <= '0;
              state  <= TRACE;
            end
          end
        end
        TRACE: begin
          len <= len_next;
          if (trace_hit) begin
            state <= EMIT;
          end else if (trace_full) begin
            state <= ERR;
          end else begin
            cur <= pred_data;
          end
        end
        EMIT: begin
          if (lifo_pop && last_beat) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign pred_addr = (state == TRACE) ? cur : '0;
  assign out_valid = (state == EMIT);
  assign out_node  = out_valid ? lifo_top : '0;
  assign out_last  = out_valid && last_beat;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE) || (state == ERR);
  assign error     = (state == ERR);

`ifdef DJ_PATH_LEN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      path_len <= '0;
    end else if ((state == IDLE) && start) begin
      path_len <= '0;
    end else if ((state == TRACE) && trace_hit) begin
      path_len <= len_next;
    end else if (state == ERR) begin
      path_len <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_dj_path_tracer.sv
// Scoreboard bench for dj_path_tracer: directed cases plus randomized tables against a path model.
module tb_dj_path_tracer;
  import dj_pkg::*;

  typedef struct {
    int node;
    int last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [NODE_W-1:0] start_node;
  logic [NODE_W-1:0] end_node;
  logic [DIST_W-1:0] end_dist;
  logic [NODE_W-1:0] pred_addr;
  logic [NODE_W-1:0] pred_data;
  logic [NODE_W-1:0] out_node;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              error;
`ifdef DJ_PATH_LEN_EN
  logic [NODE_W:0]   path_len;
`endif

  int    pred [16];
  beat_t exp_q [$];
  int    done_q [$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    ready_mode = 0;
  int    stall_node = 0;
  int    stall_cnt = 0;
  bit    prev_stall = 0;
  int    prev_node = 0;
  int    prev_last = 0;

  assign pred_data = pred[pred_addr][NODE_W-1:0];

  always #5 clk = ~clk;

  dj_path_tracer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_node (start_node),
    .end_node   (end_node),
    .end_dist   (end_dist),
    .pred_addr  (pred_addr),
    .pred_data  (pred_data),
    .out_node   (out_node),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .error      (error)
`ifdef DJ_PATH_LEN_EN
    ,
    .path_len   (path_len)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: follow predecessors from the end node, prepending, until the source or N_NODES steps.
  task automatic model_push(input int s, input int e, input int d,
                            output int lat_exp, output int err);
    int  path [$];
    int  node;
    bit  found;
    found = 0;
    if (d == 99) begin
      err = 1;
      lat_exp = 1;
    end else begin
      node = e;
      for (int i = 0; i < N_NODES && !found; i++) begin
        path.push_front(node);
        if (node == s) found = 1;
        else node = pred[node];
      end
      if (found) begin
        err = 0;
        lat_exp = 1 + path.size();
        for (int i = 0; i < path.size(); i++)
          exp_q.push_back('{node: path[i], last: (i == path.size() - 1) ? 1 : 0});
      end else begin
        err = 1;
        lat_exp = 1 + N_NODES;
      end
    end
    done_q.push_back(err);
  endtask

  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_node", int'(out_node), prev_node);
        chk("stall_last", int'(out_last), prev_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", int'(out_node), -1);
        end else begin
          b = exp_q.pop_front();
          chk("beat_node", int'(out_node), b.node);
          chk("beat_last", int'(out_last), b.last);
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done", int'(error), -1);
        else chk("done_error", int'(error), done_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_node  = int'(out_node);
      prev_last  = int'(out_last);
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 2 && out_valid && int'(out_node) == stall_node && stall_cnt < 3) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else if (ready_mode == 1) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  task automatic run_trace(input int s, input int e, input int d, input int mode_i,
                           input bit poke, input string tag);
    int lat_exp, err, lat, guard;
    model_push(s, e, d, lat_exp, err);
    ready_mode = mode_i;
    stall_cnt  = 0;
    start_node = NODE_W'(s);
    end_node   = NODE_W'(e);
    end_dist   = DIST_W'(d);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    while (!out_valid && !done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (d == 99) chk({tag, "_unreach_lat_le2"}, int'(lat <= 2), 1);
    else chk({tag, "_latency"}, lat, lat_exp);
    if (poke && out_valid) begin
      start_node = 4'd0;
      end_node   = 4'd5;
      end_dist   = 14'd99;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    guard = 0;
    while (!done && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk({tag, "_done_seen"}, int'(done), 1);
    @(posedge clk);
    #1;
    chk({tag, "_beats_left"}, exp_q.size(), 0);
    chk({tag, "_done_left"}, done_q.size(), 0);
    chk({tag, "_idle_after"}, int'(busy), 0);
  endtask

  task automatic clear_pred();
    for (int i = 0; i < 16; i++) pred[i] = 0;
  endtask

  task automatic load_case1();
    clear_pred();
    pred[2] = 8;
    pred[8] = 9;
    pred[9] = 10;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_node"}, int'(out_node), 0);
    chk({tag, "_out_last"}, int'(out_last), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_error"}, int'(error), 0);
    chk({tag, "_pred_addr"}, int'(pred_addr), 0);
  endtask

  initial begin
    int perm [N_NODES];
    int s, e, d, len, j, tmp, guard;
    rst = 1'b1;
    start = 1'b0;
    start_node = '0;
    end_node = '0;
    end_dist = '0;
    clear_pred();
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
`ifdef DJ_PATH_LEN_EN
    chk("reset_path_len", int'(path_len), 0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    load_case1();
    run_trace(10, 2, 6, 0, 0, "case1");
`ifdef DJ_PATH_LEN_EN
    chk("case1_path_len", int'(path_len), 4);
`endif

    run_trace(10, 2, 99, 0, 0, "unreach");

    run_trace(10, 10, 0, 0, 0, "single");
`ifdef DJ_PATH_LEN_EN
    chk("single_path_len", int'(path_len), 1);
`endif

    load_case1();
    stall_node = 9;
    run_trace(10, 2, 6, 2, 1, "stall");

    clear_pred();
    pred[2] = 3;
    pred[3] = 2;
    run_trace(10, 2, 5, 0, 0, "cycle");
`ifdef DJ_PATH_LEN_EN
    chk("cycle_path_len", int'(path_len), 0);
`endif

    // Abort during emission, then confirm a fresh start behaves as if nothing happened.
    load_case1();
    ready_mode = 0;
    begin
      int lat_exp, err;
      model_push(10, 2, 6, lat_exp, err);
    end
    start_node = 4'd10;
    end_node = 4'd2;
    end_dist = 14'd6;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    guard = 0;
    while (!out_valid && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("abort_reached_emit", int'(out_valid), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_quiet("abort");
    rst = 1'b0;
    exp_q.delete();
    done_q.delete();
    @(posedge clk);
    #1;
    run_trace(10, 2, 6, 0, 0, "rerun");
`ifdef DJ_PATH_LEN_EN
    chk("rerun_path_len", int'(path_len), 4);
`endif

    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < N_NODES; i++) pred[i] = $urandom_range(0, N_NODES - 1);
      s = $urandom_range(0, N_NODES - 1);
      e = $urandom_range(0, N_NODES - 1);
      if ($urandom_range(0, 2) != 0) begin
        for (int i = 0; i < N_NODES; i++) perm[i] = i;
        for (int i = N_NODES - 1; i > 0; i--) begin
          j = $urandom_range(0, i);
          tmp = perm[i];
          perm[i] = perm[j];
          perm[j] = tmp;
        end
        len = $urandom_range(1, N_NODES);
        for (int k = 1; k < len; k++) pred[perm[k]] = perm[k-1];
        s = perm[0];
        e = perm[len-1];
      end
      d = ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(0, 98);
      run_trace(s, e, d, 1, 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
